mem_axi_bridge: RTL

MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

---
 rtl/mem_axi_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
//   Converts single-cycle memory-stage requests into AXI4-Lite read or write
//   transactions, one outstanding at a time, and returns a one-cycle
//   completion pulse with read data and an error flag.
//
// Ports
//   clk, rstn                    : clock (posedge) and async active-low reset
//   request_enable, mode         : request pulse; mode 0 = read, 1 = write
//   addr, wdata, wstrb           : request address / write data / byte strobes
//   response_enable, data,       : completion pulse, read data (held until the
//   bus_error                      next response), error flag (RESP != OKAY)
//   axi_ar*/axi_r*               : AXI read address / read data channels
//   axi_aw*/axi_w*/axi_b*        : AXI write address / data / response channels
//   axi_arprot, axi_awprot       : tied to 3'b000
module mem_axi_bridge #(
  parameter logic [31:0] ADDR_OFFSET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        bus_error,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [2:0]  axi_arprot,
  output logic [2:0]  axi_awprot
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] data_q, data_d;
  logic        resp_q, resp_d;
  logic        err_q, err_d;

  logic aw_fire;
  logic w_fire;

  // Valid/ready decode straight from state so reset clears them immediately.
  assign axi_arvalid = (state_q == RD_ADDR);
  assign axi_rready  = (state_q == RD_DATA);
  assign axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi_bready  = (state_q == WR_RESP);

  assign aw_fire = axi_awvalid && axi_awready;
  assign w_fire  = axi_wvalid && axi_wready;

  assign axi_araddr = addr_q;
  assign axi_awaddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_arprot = '0;
  assign axi_awprot = '0;

  assign response_enable = resp_q;
  assign bus_error       = err_q;
  assign data            = data_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_d    = data_q;
    resp_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (request_enable) begin
          addr_d    = addr - ADDR_OFFSET;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = mode ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (axi_rvalid) begin
          data_d  = axi_rdata;
          err_d   = (axi_rresp != 2'b00);
          resp_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // Each channel completes independently; a same-cycle double
        // handshake exits straight away.
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_bvalid) begin
          data_d  = '0;
          err_d   = (axi_bresp != 2'b00);
          resp_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_q    <= '0;
      resp_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

endmodule
